// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: decodes one instruction per FETCH..DONE pass and
// sequences datapath strobes through setup, settle, memory, write-back and halt.
module control_unit_mc #(
    parameter int BUF_CYC     = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [4:0] func,
    input  logic       INT,
    input  logic       mem_ready,
    output logic [3:0] aluOp,
    output logic [2:0] brOp,
    output logic       aluSrc,
    output logic       regAluOut,
    output logic       rdMem,
    output logic       wrMem,
    output logic       wrReg,
    output logic       mToReg,
    output logic       immSel,
    output logic       updPC,
    output logic       isCmov,
    output logic       illegal,
    output logic       mem_err,
    output logic       halted
);

    typedef enum logic [2:0] {
        FETCH, SETUP, BUF, MEM, WB, HALTED, DONE
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_CMOV, C_BR, C_LD, C_ST, C_HALT, C_NOP, C_ILL
    } cls_t;

    state_t      state, next_state;
    cls_t        cls, dec_cls, cls_now;
    logic [15:0] cyc_cnt;
    logic [3:0]  dec_alu_op;
    logic [2:0]  dec_br_op;
    logic        dec_alu_src, dec_reg_alu_out, dec_imm_sel;
    logic        buf_last, mem_timeout;
    logic        unused_func;

    assign unused_func = func[4];

    always_comb begin
        dec_cls         = C_ILL;
        dec_alu_op      = 4'h0;
        dec_br_op       = 3'b100;
        dec_alu_src     = 1'b0;
        dec_reg_alu_out = 1'b0;
        dec_imm_sel     = 1'b0;
        if (opcode == 6'h00) begin
            dec_cls         = C_ALU;
            dec_alu_op      = func[3:0] - 4'd1;
            dec_alu_src     = 1'b1;
            dec_reg_alu_out = 1'b1;
        end else if (opcode <= 6'h0F) begin
            dec_cls    = C_ALU;
            dec_alu_op = opcode[3:0] - 4'd1;
        end else begin
            case (opcode)
                6'h10: begin
                    dec_cls    = C_ALU;
                    dec_alu_op = 4'hF;
                end
                6'h11: dec_cls = C_LD;
                6'h12: dec_cls = C_ST;
                6'h14, 6'h15: begin
                    dec_cls         = (opcode == 6'h15) ? C_CMOV : C_ALU;
                    dec_alu_src     = 1'b1;
                    dec_reg_alu_out = 1'b1;
                end
                6'h20, 6'h21, 6'h22, 6'h23: begin
                    dec_cls     = C_BR;
                    dec_br_op   = {1'b0, opcode[1:0]};
                    dec_imm_sel = 1'b1;
                end
                6'h24:   dec_cls = C_HALT;
                6'h25:   dec_cls = C_NOP;
                default: dec_cls = C_ILL;
            endcase
        end
    end

    // The class register is only valid after SETUP, so SETUP decisions use the live decode.
    assign cls_now     = (state == SETUP) ? dec_cls : cls;
    assign buf_last    = (cyc_cnt == 16'(BUF_CYC - 1));
    assign mem_timeout = (MEM_TIMEOUT != 0) && (cyc_cnt == 16'(MEM_TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            FETCH: next_state = SETUP;
            SETUP: begin
                case (dec_cls)
                    C_ALU:        next_state = WB;
                    C_CMOV, C_BR: next_state = BUF;
                    C_LD, C_ST:   next_state = MEM;
                    C_HALT:       next_state = HALTED;
                    default:      next_state = DONE;
                endcase
            end
            BUF: begin
                if (buf_last) next_state = (cls == C_CMOV) ? WB : DONE;
            end
            MEM: begin
                if (mem_ready)        next_state = (cls == C_LD) ? WB : DONE;
                else if (mem_timeout) next_state = DONE;
            end
            WB:      next_state = DONE;
            HALTED:  if (INT) next_state = DONE;
            DONE:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Every output is registered from the state being entered, so strobes line up with their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            cls       <= C_NOP;
            cyc_cnt   <= '0;
            aluOp     <= 4'h0;
            brOp      <= 3'b100;
            aluSrc    <= 1'b0;
            regAluOut <= 1'b0;
            immSel    <= 1'b0;
            rdMem     <= 1'b0;
            wrMem     <= 1'b0;
            wrReg     <= 1'b0;
            mToReg    <= 1'b0;
            updPC     <= 1'b0;
            isCmov    <= 1'b0;
            illegal   <= 1'b0;
            mem_err   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state   <= next_state;
            cyc_cnt <= ((state == BUF || state == MEM) && next_state == state) ?
                       cyc_cnt + 16'd1 : 16'd0;
            updPC   <= (next_state == DONE);
            wrReg   <= (next_state == WB);
            mToReg  <= (next_state == WB) && (state == MEM);
            rdMem   <= (next_state == MEM) && (cls_now == C_LD);
            wrMem   <= (next_state == MEM) && (cls_now == C_ST);
            halted  <= (next_state == HALTED);
            isCmov  <= (next_state == BUF || next_state == WB) && (cls_now == C_CMOV);
            illegal <= (state == SETUP) && (dec_cls == C_ILL);
            mem_err <= (state == MEM) && (next_state == DONE) && !mem_ready;
            if (state == SETUP) begin
                cls       <= dec_cls;
                aluOp     <= dec_alu_op;
                brOp      <= dec_br_op;
                aluSrc    <= dec_alu_src;
                regAluOut <= dec_reg_alu_out;
                immSel    <= dec_imm_sel;
            end else if (next_state == FETCH) begin
                aluOp     <= 4'h0;
                brOp      <= 3'b100;
                aluSrc    <= 1'b0;
                regAluOut <= 1'b0;
                immSel    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Testbench for control_unit_mc: table vectors, reset corner sequences and
// random instructions compared cycle by cycle against a trace model.
module tb_control_unit_mc;

    localparam int BUFC = 3;
    localparam int MEMTO = 16;
    localparam int K_ALU = 0, K_CMOV = 1, K_BR = 2, K_LD = 3, K_ST = 4, K_HALT = 5, K_NOP = 6, K_ILL = 7;

    typedef struct packed {
        logic [3:0] aluOp;
        logic [2:0] brOp;
        logic aluSrc, regAluOut, rdMem, wrMem, wrReg, mToReg;
        logic immSel, updPC, isCmov, illegal, mem_err, halted;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [4:0] fn;
        int         readyAt;
        int         intAt;
        logic [3:0] expAlu;
        logic [2:0] expBr;
        int         expDone;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [4:0] func = '0;
    logic INT = 1'b0, mem_ready = 1'b0;
    logic [3:0] aluOp;
    logic [2:0] brOp;
    logic aluSrc, regAluOut, rdMem, wrMem, wrReg, mToReg, immSel, updPC, isCmov, illegal, mem_err, halted;

    int checkCount = 0;
    int errorCount = 0;
    outs_t expQ[$];
    outs_t idleVec;

    control_unit_mc #(.BUF_CYC(BUFC), .MEM_TIMEOUT(MEMTO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .INT(INT),
        .mem_ready(mem_ready), .aluOp(aluOp), .brOp(brOp), .aluSrc(aluSrc),
        .regAluOut(regAluOut), .rdMem(rdMem), .wrMem(wrMem), .wrReg(wrReg),
        .mToReg(mToReg), .immSel(immSel), .updPC(updPC), .isCmov(isCmov),
        .illegal(illegal), .mem_err(mem_err), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic outs_t sampleDut();
        outs_t s;
        s = '{aluOp: aluOp, brOp: brOp, aluSrc: aluSrc, regAluOut: regAluOut, rdMem: rdMem,
              wrMem: wrMem, wrReg: wrReg, mToReg: mToReg, immSel: immSel, updPC: updPC,
              isCmov: isCmov, illegal: illegal, mem_err: mem_err, halted: halted};
        return s;
    endfunction

    function automatic int classOf(logic [5:0] op);
        if (op <= 6'h10 || op == 6'h14) return K_ALU;
        if (op == 6'h15) return K_CMOV;
        if (op == 6'h11) return K_LD;
        if (op == 6'h12) return K_ST;
        if (op >= 6'h20 && op <= 6'h23) return K_BR;
        if (op == 6'h24) return K_HALT;
        if (op == 6'h25) return K_NOP;
        return K_ILL;
    endfunction

    function automatic outs_t decFields(logic [5:0] op, logic [4:0] fn);
        outs_t d;
        int    opi, fni;
        d = '0;
        d.brOp = 3'b100;
        opi = int'(op);
        fni = int'(fn);
        if (opi == 0) begin
            d.aluOp = 4'(((fni % 16) + 15) % 16);
            d.aluSrc = 1'b1;
            d.regAluOut = 1'b1;
        end else if (opi < 16) begin
            d.aluOp = 4'((opi + 15) % 16);
        end else if (opi == 16) begin
            d.aluOp = 4'hF;
        end else if (opi == 20 || opi == 21) begin
            d.aluSrc = 1'b1;
            d.regAluOut = 1'b1;
        end else if (opi >= 32 && opi <= 35) begin
            d.brOp = 3'(opi - 32);
            d.immSel = 1'b1;
        end
        return d;
    endfunction

    // Expected outputs for each cycle of one instruction, starting at its FETCH cycle.
    task automatic buildTrace(input logic [5:0] op, input logic [4:0] fn, input int readyAt, input int intAt);
        outs_t d, v;
        int    cls, memCycles, haltCycles;
        bit    timedOut;
        expQ.delete();
        d = decFields(op, fn);
        cls = classOf(op);
        memCycles = ((readyAt > 2) ? readyAt : 2) - 1;
        timedOut = (memCycles > MEMTO);
        if (timedOut) memCycles = MEMTO;
        haltCycles = ((intAt > 2) ? intAt : 2) - 1;
        expQ.push_back(idleVec);
        expQ.push_back(idleVec);
        v = d;
        case (cls)
            K_ALU: begin v.wrReg = 1'b1; expQ.push_back(v); end
            K_CMOV: begin
                v.isCmov = 1'b1;
                for (int k = 0; k < BUFC; k++) expQ.push_back(v);
                v.wrReg = 1'b1;
                expQ.push_back(v);
            end
            K_BR: for (int k = 0; k < BUFC; k++) expQ.push_back(v);
            K_LD: begin
                v.rdMem = 1'b1;
                for (int k = 0; k < memCycles; k++) expQ.push_back(v);
                if (!timedOut) begin
                    v = d;
                    v.mToReg = 1'b1;
                    v.wrReg = 1'b1;
                    expQ.push_back(v);
                end
            end
            K_ST: begin
                v.wrMem = 1'b1;
                for (int k = 0; k < memCycles; k++) expQ.push_back(v);
            end
            K_HALT: begin
                v.halted = 1'b1;
                for (int k = 0; k < haltCycles; k++) expQ.push_back(v);
            end
            default: ;
        endcase
        v = d;
        v.updPC = 1'b1;
        v.illegal = (cls == K_ILL);
        v.mem_err = timedOut && (cls == K_LD || cls == K_ST);
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] fn, input logic rdy, input logic irq);
        opcode = op;
        func = fn;
        mem_ready = rdy;
        INT = irq;
    endtask

    // Called at the negedge of the instruction's FETCH cycle; returns at the next one (or after maxCycles).
    task automatic runInstr(input string name, input logic [5:0] op, input logic [4:0] fn,
                            input int readyAt, input int intAt, input int maxCycles,
                            output logic [3:0] obsAlu, output logic [2:0] obsBr, output int obsDone);
        outs_t act;
        int    n;
        buildTrace(op, fn, readyAt, intAt);
        n = (expQ.size() < maxCycles) ? expQ.size() : maxCycles;
        obsAlu = 4'h0;
        obsBr = 3'b000;
        obsDone = -1;
        for (int i = 0; i < n; i++) begin
            act = sampleDut();
            checkOutput($sformatf("%s c%0d", name, i), 32'(act), 32'(expQ[i]));
            if (act.updPC && obsDone < 0) obsDone = i;
            if (i == 2) begin
                obsAlu = act.aluOp;
                obsBr = act.brOp;
            end
            applyStimulus((i == 1) ? op : 6'($urandom), (i == 1) ? fn : 5'($urandom),
                          (i >= readyAt), (i >= intAt));
            @(negedge clk);
        end
    endtask

    task automatic resetMid(input string name);
        #2 rst_n = 1'b0;
        #1 checkOutput({name, " async"}, 32'(sampleDut()), 32'(idleVec));
        @(negedge clk);
        checkOutput({name, " held"}, 32'(sampleDut()), 32'(idleVec));
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t       vecs[17];
        logic [3:0] oa;
        logic [2:0] ob;
        int         od;
        logic [5:0] legal[14];
        logic [5:0] op;

        idleVec = '0;
        idleVec.brOp = 3'b100;
        legal = '{6'h00, 6'h05, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h14,
                  6'h15, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25};

        vecs[0]  = '{"rtype",    6'h00, 5'h03, 99, 99, 4'h2, 3'b100, 3};
        vecs[1]  = '{"aluimm",   6'h05, 5'h00, 99, 99, 4'h4, 3'b100, 3};
        vecs[2]  = '{"lui",      6'h10, 5'h00, 99, 99, 4'hF, 3'b100, 3};
        vecs[3]  = '{"move",     6'h14, 5'h00, 99, 99, 4'h0, 3'b100, 3};
        vecs[4]  = '{"cmov",     6'h15, 5'h00, 99, 99, 4'h0, 3'b100, 6};
        vecs[5]  = '{"bz",       6'h23, 5'h00, 99, 99, 4'h0, 3'b011, 5};
        vecs[6]  = '{"br",       6'h20, 5'h00, 99, 99, 4'h0, 3'b000, 5};
        vecs[7]  = '{"ld5",      6'h11, 5'h00, 6,  99, 4'h0, 3'b100, 8};
        vecs[8]  = '{"stready",  6'h12, 5'h00, 0,  99, 4'h0, 3'b100, 3};
        vecs[9]  = '{"sttimeout",6'h12, 5'h00, 99, 99, 4'h0, 3'b100, 18};
        vecs[10] = '{"halt20",   6'h24, 5'h00, 99, 21, 4'h0, 3'b100, 22};
        vecs[11] = '{"ill3f",    6'h3F, 5'h00, 99, 99, 4'h0, 3'b100, 2};
        vecs[12] = '{"nop",      6'h25, 5'h00, 99, 0,  4'h0, 3'b100, 2};
        vecs[13] = '{"ill13",    6'h13, 5'h00, 0,  0,  4'h0, 3'b100, 2};
        vecs[14] = '{"rtypewrap",6'h00, 5'h10, 99, 99, 4'hF, 3'b100, 3};
        vecs[15] = '{"ldtimeout",6'h11, 5'h00, 99, 99, 4'h0, 3'b100, 18};
        vecs[16] = '{"ldlast",   6'h11, 5'h00, 17, 99, 4'h0, 3'b100, 19};

        applyStimulus(6'h00, 5'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("resetState", 32'(sampleDut()), 32'(idleVec));
        rst_n = 1'b1;

        foreach (vecs[t]) begin
            runInstr(vecs[t].name, vecs[t].op, vecs[t].fn, vecs[t].readyAt, vecs[t].intAt, 1000, oa, ob, od);
            checkOutput({vecs[t].name, " aluOp"}, 32'(oa), 32'(vecs[t].expAlu));
            checkOutput({vecs[t].name, " brOp"}, 32'(ob), 32'(vecs[t].expBr));
            checkOutput({vecs[t].name, " updPC cycle"}, 32'(od), 32'(vecs[t].expDone));
        end

        runInstr("haltabort", 6'h24, 5'h00, 99, 99, 8, oa, ob, od);
        resetMid("rstHalt");
        runInstr("afterHalt", 6'h00, 5'h03, 99, 99, 1000, oa, ob, od);
        runInstr("ldabort", 6'h11, 5'h00, 99, 99, 6, oa, ob, od);
        resetMid("rstMem");
        runInstr("afterMem", 6'h25, 5'h00, 99, 99, 1000, oa, ob, od);
        runInstr("bzabort", 6'h23, 5'h00, 99, 99, 3, oa, ob, od);
        resetMid("rstBuf");
        runInstr("afterBuf", 6'h3F, 5'h00, 99, 99, 1000, oa, ob, od);
        runInstr("afterIll", 6'h00, 5'h03, 99, 99, 1000, oa, ob, od);

        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = legal[$urandom_range(0, 13)];
            runInstr($sformatf("rand%0d op%h", r, op), op, 5'($urandom),
                     int'($urandom_range(0, 22)), int'($urandom_range(0, 14)), 1000, oa, ob, od);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
